// File: rtl/mult_ctrl_if.sv
// Execute-stage multiplier bundle: start/operands from the pipeline, status and
// HI/LO back to the pipeline and hazard unit.
interface mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             MultStartE;
  logic             MultSgnE;
  logic             FlushE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             HiLoReadD;
  logic             MultBusyE;
  logic             MultStallD;
  logic             MultDoneE;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;

  modport master (
    output MultStartE, MultSgnE, FlushE, SrcAE, SrcBE, HiLoReadD,
    input  MultBusyE, MultStallD, MultDoneE, HiOut, LoOut
  );

  modport slave (
    input  MultStartE, MultSgnE, FlushE, SrcAE, SrcBE, HiLoReadD,
    output MultBusyE, MultStallD, MultDoneE, HiOut, LoOut
  );
endinterface

// File: rtl/mult_ctrl.sv
// Iterative shift-add multiplier controller: one product bit per cycle on
// operand magnitudes, sign restored once at the end before committing HI/LO.
module mult_ctrl #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  mult_ctrl_if.slave bus
);
  localparam int CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT              state;
  logic [CntW-1:0]    count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     partial;
  logic               negate;
  logic               doneReg;
  logic               accept;
  logic               busy;

  assign accept = bus.MultStartE & ~bus.FlushE;
  assign busy   = (state != IDLE);

  // The upper half keeps its carry so the shift brings it into the product.
  always_comb begin
    absA    = (bus.MultSgnE & bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
    absB    = (bus.MultSgnE & bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    product = negate ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      negate  <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= absA;
            mplier <= absB;
            negate <= bus.MultSgnE & (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
            acc    <= '0;
            count  <= CntW'(WIDTH);
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= {partial, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CntW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hiReg   <= product[2*WIDTH-1:WIDTH];
          loReg   <= product[WIDTH-1:0];
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MultBusyE  = busy;
  assign bus.MultStallD = busy & (bus.HiLoReadD | bus.MultStartE);
  assign bus.MultDoneE  = doneReg;
  assign bus.HiOut      = hiReg;
  assign bus.LoOut      = loReg;
endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboarded bench for mult_ctrl: accepted multiplies queue their expected
// HI/LO, and a monitor compares whenever MultDoneE pulses.
module tb_mult_ctrl;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  mult_ctrl_if #(.WIDTH(WIDTH)) bus();

  mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] lastProd = '0;
  logic [63:0] monExp;
  logic [31:0] nextA;
  logic [31:0] nextB;
  logic        nextSgn;

  // Reference product straight from integer arithmetic on the operand values.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    longint sa;
    longint sb;
    longint sp;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      return 64'(sp);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.MultDoneE === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got MultDoneE=1, expected 0 (nothing pending)");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("HiOut", 64'(bus.HiOut), 64'(monExp[63:32]));
        checkOutput("LoOut", 64'(bus.LoOut), 64'(monExp[31:0]));
      end
    end
  end

  // mode 0: plain, 1: random FlushE while running, 2: HiLoReadD from T0+5,
  // 3: second start (nextA/nextB/nextSgn) held from T0+3 and left asserted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sgn, input int mode);
    int doneEdge;
    bus.SrcAE      = a;
    bus.SrcBE      = b;
    bus.MultSgnE   = sgn;
    bus.FlushE     = 1'b0;
    bus.MultStartE = 1'b1;
    @(posedge clk);
    expQ.push_back(refProduct(a, b, sgn));
    lastProd = refProduct(a, b, sgn);
    #1;
    bus.MultStartE = 1'b0;
    bus.SrcAE      = $urandom;
    bus.SrcBE      = $urandom;
    bus.MultSgnE   = 1'($urandom_range(0, 1));
    doneEdge = 0;
    for (int k = 1; k <= WIDTH + 8 && doneEdge == 0; k++) begin
      @(posedge clk);
      #1;
      if (mode == 1) bus.FlushE = (k <= WIDTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 2 && k == 5) bus.HiLoReadD = 1'b1;
      if (mode == 3 && k == 3) begin
        bus.SrcAE      = nextA;
        bus.SrcBE      = nextB;
        bus.MultSgnE   = nextSgn;
        bus.MultStartE = 1'b1;
      end
      @(negedge clk);
      if (k == 1) checkOutput("busyAfterAccept", 64'(bus.MultBusyE), 64'd1);
      if (mode == 2 && k >= 5 && k <= WIDTH)
        checkOutput("stallHiLoRead", 64'(bus.MultStallD), 64'd1);
      if (mode == 3 && k >= 3 && k <= WIDTH)
        checkOutput("stallSecondStart", 64'(bus.MultStallD), 64'd1);
      if (bus.MultDoneE === 1'b1) doneEdge = k + 1;
    end
    if (doneEdge == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no MultDoneE within %0d edges, expected edge T0+%0d",
               WIDTH + 8, WIDTH + 2);
    end else begin
      checkOutput("doneLatency", 64'(doneEdge), 64'(WIDTH + 2));
      checkOutput("busyInDone", 64'(bus.MultBusyE), 64'd0);
      if (mode == 2 || mode == 3) checkOutput("stallInDone", 64'(bus.MultStallD), 64'd0);
    end
    bus.FlushE    = 1'b0;
    bus.HiLoReadD = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b0;
    bus.MultStartE = 1'b1;
    bus.MultSgnE   = 1'b0;
    bus.FlushE     = 1'b0;
    bus.SrcAE      = 32'h7;
    bus.SrcBE      = 32'h5;
    bus.HiLoReadD  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", 64'(bus.MultBusyE), 64'd0);
    checkOutput("resetDone", 64'(bus.MultDoneE), 64'd0);
    checkOutput("resetStall", 64'(bus.MultStallD), 64'd0);
    checkOutput("resetHi", 64'(bus.HiOut), 64'd0);
    checkOutput("resetLo", 64'(bus.LoOut), 64'd0);
    bus.MultStartE = 1'b0;
    bus.HiLoReadD  = 1'b0;
    rst            = 1'b1;
    @(negedge clk);

    applyStimulus(32'h7, 32'h5, 1'b0, 0);
    applyStimulus(32'hFFFFFFFD, 32'h5, 1'b1, 0);
    applyStimulus(32'hFFFFFFFD, 32'h5, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus(32'h80000000, 32'h80000000, 1'b1, 0);
    applyStimulus($urandom, $urandom, 1'b1, 2);

    nextA   = $urandom;
    nextB   = $urandom;
    nextSgn = 1'b1;
    applyStimulus($urandom, $urandom, 1'b0, 3);
    applyStimulus(nextA, nextB, nextSgn, 0);

    bus.SrcAE      = $urandom;
    bus.SrcBE      = $urandom;
    bus.MultStartE = 1'b1;
    bus.FlushE     = 1'b1;
    @(posedge clk);
    #1;
    bus.MultStartE = 1'b0;
    bus.FlushE     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("flushNoBusy", 64'(bus.MultBusyE), 64'd0);
    checkOutput("flushHiKept", 64'(bus.HiOut), 64'(lastProd[63:32]));
    checkOutput("flushLoKept", 64'(bus.LoOut), 64'(lastProd[31:0]));

    bus.SrcAE      = 32'h01234567;
    bus.SrcBE      = 32'h89ABCDEF;
    bus.MultSgnE   = 1'b0;
    bus.MultStartE = 1'b1;
    @(posedge clk);
    #1;
    bus.MultStartE = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midResetBusy", 64'(bus.MultBusyE), 64'd0);
    checkOutput("midResetDone", 64'(bus.MultDoneE), 64'd0);
    checkOutput("midResetHi", 64'(bus.HiOut), 64'd0);
    checkOutput("midResetLo", 64'(bus.LoOut), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (WIDTH + 8) @(negedge clk);
    checkOutput("postResetHi", 64'(bus.HiOut), 64'd0);
    checkOutput("postResetLo", 64'(bus.LoOut), 64'd0);
    applyStimulus(32'h7, 32'h5, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end

    repeat (WIDTH + 8) @(negedge clk);
    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
